// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use and MDU hazards,
// branch/jump flushes, the MDU issue FSM and saturating perf counters.
module pipe_hazard_ctrl #(
  parameter int MUL_LAT = 4,
  parameter int DIV_LAT = 32,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_use_rs,
  input  logic             id_use_rt,
  input  logic             ex_mem_read,
  input  logic [4:0]       ex_rt,
  input  logic             ex_branch_taken,
  input  logic             id_jump,
  input  logic             id_mdu_start,
  input  logic             id_mdu_div,
  input  logic             id_hilo_read,
  output logic             pc_write,
  output logic             ifid_write,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             mdu_busy,
  output logic             mdu_done,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count
);

  // Sized for the longer latency so an oversized MUL_LAT cannot truncate the reload.
  localparam int MAX_LAT = (DIV_LAT > MUL_LAT) ? DIV_LAT : MUL_LAT;
  localparam int CW      = (MAX_LAT > 2) ? $clog2(MAX_LAT) : 1;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic          load_use, mdu_stall, stall, accept, flush_evt;

  assign load_use  = ex_mem_read && (ex_rt != 5'd0) &&
                     ((id_use_rs && (id_rs == ex_rt)) || (id_use_rt && (id_rt == ex_rt)));
  assign mdu_stall = (state == BUSY) && (id_hilo_read || id_mdu_start);
  assign stall     = (load_use || mdu_stall) && !ex_branch_taken;
  assign accept    = id_mdu_start && !stall && !ex_branch_taken;
  // A jump held by a stall does not redirect fetch, so it is not a flush event.
  assign flush_evt = ex_branch_taken || (!stall && id_jump);

  assign mdu_busy = (state == BUSY);
  assign mdu_done = (state == DONE);

  always_comb begin
    pc_write   = 1'b1;
    ifid_write = 1'b1;
    ifid_flush = 1'b0;
    idex_flush = 1'b0;
    if (!reset_n) begin
      pc_write   = 1'b0;
      ifid_write = 1'b0;
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
    end else if (ex_branch_taken) begin
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
    end else if (stall) begin
      pc_write   = 1'b0;
      ifid_write = 1'b0;
      idex_flush = 1'b1;
    end else if (id_jump) begin
      ifid_flush = 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      IDLE, DONE: begin
        state_nxt = IDLE;
        if (accept) begin
          state_nxt = BUSY;
          cnt_nxt   = id_mdu_div ? CW'(DIV_LAT - 2) : CW'(MUL_LAT - 2);
        end
      end
      BUSY: begin
        if (cnt == '0) state_nxt = DONE;
        else           cnt_nxt   = cnt - CW'(1);
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stall_count <= '0;
      flush_count <= '0;
    end else begin
      if (stall && (stall_count != '1))     stall_count <= stall_count + CNT_W'(1);
      if (flush_evt && (flush_count != '1)) flush_count <= flush_count + CNT_W'(1);
    end
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Central stall/flush sequencer for the 5-stage pipeline.
- Drives PC write-enable, IF/ID write-enable and flush, and the ID/EX register's CFlush bubble input.
- Detects load-use hazards against the ID/EX stage and handles taken branches (resolved in EX) and jumps (resolved in ID).
- Owns the issue FSM for the multi-cycle multiply/divide unit (MDU) and keeps saturating stall/flush performance counters.

Parameters:
MUL_LAT, 4, MDU multiply latency in cycles (>=2)
DIV_LAT, 32, MDU divide latency in cycles (>=2)
CNT_W, 16, width of performance counters

Ports:
clk  in  1  pipeline clock
reset_n  in  1  asynchronous reset, active-low
id_rs  in  5  rs field of instruction in ID
id_rt  in  5  rt field of instruction in ID
id_use_rs  in  1  ID instruction reads rs
id_use_rt  in  1  ID instruction reads rt
ex_mem_read  in  1  MemRead control currently held in ID/EX
ex_rt  in  5  Rt currently held in ID/EX
ex_branch_taken  in  1  branch in EX resolved taken
id_jump  in  1  ID instruction is a jump
id_mdu_start  in  1  ID instruction is mult/div
id_mdu_div  in  1  with id_mdu_start: 1=divide, 0=multiply
id_hilo_read  in  1  ID instruction reads HI/LO (mfhi/mflo)
pc_write  out  1  PC update enable
ifid_write  out  1  IF/ID update enable
ifid_flush  out  1  IF/ID clear
idex_flush  out  1  drives ID/EX CFlush
mdu_busy  out  1  MDU operation in progress
mdu_done  out  1  one-cycle pulse when MDU result valid
stall_count  out  CNT_W  stall cycles, saturating
flush_count  out  CNT_W  flush events, saturating

Behaviour:
- Hazard terms (combinational from inputs and current state):
  - load_use = ex_mem_read & (ex_rt != 0) & ((id_use_rs & id_rs == ex_rt) | (id_use_rt & id_rt == ex_rt)).
  - mdu_stall = (state == BUSY) & (id_hilo_read | id_mdu_start).
  - stall = (load_use | mdu_stall) & ~ex_branch_taken.
- Control outputs, combinational, evaluated in priority order:
  1. ex_branch_taken: pc_write=1, ifid_write=1, ifid_flush=1, idex_flush=1. Branch dominates stall and jump.
  2. stall: pc_write=0, ifid_write=0, ifid_flush=0, idex_flush=1 (bubble inserted, ID instruction held).
  3. id_jump: pc_write=1, ifid_write=1, ifid_flush=1, idex_flush=0.
  4. Otherwise: pc_write=1, ifid_write=1, both flushes 0.
- MDU FSM, states IDLE / BUSY / DONE, 1-hot or binary, with down-counter cnt of width clog2(DIV_LAT):
  - accept = id_mdu_start & ~stall & ~ex_branch_taken.
  - IDLE: on accept, cnt <= (id_mdu_div ? DIV_LAT : MUL_LAT) - 2 and go to BUSY.
  - BUSY: mdu_busy=1. cnt decrements each cycle; when cnt == 0, go to DONE. Total BUSY length is LAT-1 cycles.
  - DONE: mdu_done=1 for exactly one cycle. On accept, reload cnt and go to BUSY; otherwise go to IDLE.
  - A start or HI/LO read in ID while BUSY stalls until the DONE cycle. In DONE neither stalls.
  - A taken branch never cancels an operation already in BUSY.
- Counters (registered, visible the cycle after the event):
  - stall_count += 1 on every cycle with stall=1.
  - flush_count += 1 on every cycle with ifid_flush=1 (branch or jump; a branch+jump in the same cycle counts once).
  - Both hold at 2^CNT_W-1 once reached.
- Reset: reset_n low asynchronously forces state=IDLE, cnt=0, stall_count=0, flush_count=0, mdu_busy=0, mdu_done=0.
  - While reset_n is low, outputs are overridden: pc_write=0, ifid_write=0, ifid_flush=1, idex_flush=1.
  - Reset asserted during BUSY aborts the operation with no mdu_done pulse.
- Register zero: ex_rt == 0 never triggers load-use.
- The output path carries no latency; all control outputs respond in the same cycle as their inputs.

Test Plan:
- Load-use: ex_mem_read=1, ex_rt=5, id_use_rt=1, id_rt=5 for one cycle -> pc_write=0, ifid_write=0, idex_flush=1; next cycle stall_count=1. Repeat with ex_rt=0 -> no stall.
- Branch vs stall: same load-use condition plus ex_branch_taken=1 -> pc_write=1, ifid_flush=1, idex_flush=1, stall_count unchanged, flush_count+1.
- Multiply: id_mdu_start=1, id_mdu_div=0 accepted at cycle 0 -> mdu_busy high cycles 1-3, mdu_done pulse at cycle 4. An id_hilo_read held from cycle 1 stalls 3 cycles and is released in cycle 4.
- Back-to-back divide: accept a div, then assert id_mdu_start throughout -> stall during the 31 BUSY cycles; second op is accepted in the DONE cycle and re-enters BUSY with no IDLE cycle.
- Saturation: CNT_W=4, hold load-use for 20 cycles -> stall_count reaches 15 and stays at 15.
- Reset mid-op: drop reset_n at BUSY cycle 10 of a divide -> mdu_busy=0 immediately, no mdu_done, counters 0, pc_write=0 and both flushes 1 while low.
